uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART definitions: rx state encoding, prescale constants
//             and the parity helper used by both the RX and TX sides.
//             The PARITY state exists only when UART_RX_PARITY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } rx_state_t;

    // Narrower words are zero-extended by the caller; zeros do not alter parity.
    function automatic logic parity_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Brief    : Captures the line at three mid-bit edge counts and presents the
//             2-of-3 majority vote as the decided bit value.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_line,
    input  logic [PRESCALE_W-1:0] i_edge_cnt,
    input  logic [PRESCALE_W-1:0] i_half,
    output logic                  o_bit
);

    logic [2:0] r_smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp <= 3'b111;
        end else begin
            if (i_edge_cnt == i_half - PRESCALE_W'(1)) r_smp[0] <= i_line;
            if (i_edge_cnt == i_half)                  r_smp[1] <= i_line;
            if (i_edge_cnt == i_half + PRESCALE_W'(1)) r_smp[2] <= i_line;
        end
    end

    assign o_bit = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : Oversampling UART receiver with majority-vote bit decisions,
//             optional parity (enabled by macro UART_RX_PARITY_EN) and
//             one-cycle valid / error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [1:0]            r_sync;
    rx_state_t             r_state, w_state_nxt;
    logic [PRESCALE_W-1:0] r_edge_cnt, w_edge_nxt;
    logic [c_BIT_W-1:0]    r_bit_cnt, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [PRESCALE_W-1:0] r_presc, w_presc_nxt, w_presc_norm;
    logic [DATA_WIDTH-1:0] r_p_data, w_pdata_nxt;
    logic                  r_dv, w_dv_nxt;
    logic                  r_se, w_se_nxt;
    logic                  w_line, w_bit, w_decide, w_last, w_perr;
    logic [PRESCALE_W-1:0] w_half;

`ifdef UART_RX_PARITY_EN
    logic r_par_en, w_par_en_nxt;
    logic r_par_typ, w_par_typ_nxt;
    logic r_par_flag, w_flag_nxt;
    logic r_pe, w_pe_nxt;
    assign w_perr  = r_par_flag;
    assign par_err = r_pe;
`else
    logic w_unused_par;
    assign w_unused_par = PAR_EN ^ PAR_TYP;
    assign w_perr       = 1'b0;
    assign par_err      = 1'b0;
`endif

    assign w_line   = r_sync[1];
    assign w_half   = r_presc >> 1;
    assign w_decide = (r_edge_cnt == w_half + PRESCALE_W'(2));
    assign w_last   = (r_edge_cnt == r_presc - PRESCALE_W'(1));

    // Unsupported ratios fall back to the slowest-sampling legal setting.
    always_comb begin
        w_presc_norm = PRESCALE_W'(PRESCALE_8);
        if (Prescale == PRESCALE_W'(PRESCALE_16) || Prescale == PRESCALE_W'(PRESCALE_32))
            w_presc_norm = Prescale;
    end

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk        (clk),
        .rst        (RST),
        .i_line     (w_line),
        .i_edge_cnt (r_edge_cnt),
        .i_half     (w_half),
        .o_bit      (w_bit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = r_edge_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_presc_nxt = r_presc;
        w_pdata_nxt = r_p_data;
        w_dv_nxt    = 1'b0;
        w_se_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
        w_flag_nxt    = r_par_flag;
        w_pe_nxt      = 1'b0;
`endif
        if (r_state != IDLE)
            w_edge_nxt = w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);

        case (r_state)
            IDLE: begin
                w_edge_nxt = '0;
                w_bit_nxt  = '0;
                // The cycle that first sees the low line is edge 0 of the start bit.
                if (!w_line) begin
                    w_state_nxt = START;
                    w_edge_nxt  = PRESCALE_W'(1);
                    w_presc_nxt = w_presc_norm;
`ifdef UART_RX_PARITY_EN
                    w_par_en_nxt  = PAR_EN;
                    w_par_typ_nxt = PAR_TYP;
                    w_flag_nxt    = 1'b0;
`endif
                end
            end
            START: begin
                if (w_decide && w_bit) begin
                    w_state_nxt = IDLE;
                    w_edge_nxt  = '0;
                end else if (w_last) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                end
            end
            DATA: begin
                if (w_decide)
                    w_shift_nxt = {w_bit, r_shift[DATA_WIDTH-1:1]};
                if (w_last) begin
                    if (r_bit_cnt == c_BIT_W'(DATA_WIDTH - 1)) begin
                        w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = r_par_en ? PARITY : STOP;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + c_BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_decide && (w_bit != parity_calc(32'(r_shift), r_par_typ)))
                    w_flag_nxt = 1'b1;
                if (w_last)
                    w_state_nxt = STOP;
            end
`endif
            STOP: begin
                // Leave half a bit early so an immediately following start edge is seen.
                if (w_decide) begin
                    w_state_nxt = IDLE;
                    w_edge_nxt  = '0;
                    w_se_nxt    = !w_bit;
                    if (w_bit && !w_perr) begin
                        w_pdata_nxt = r_shift;
                        w_dv_nxt    = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    w_pe_nxt = r_par_flag;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_edge_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_sync     <= 2'b11;
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_presc    <= PRESCALE_W'(PRESCALE_8);
            r_p_data   <= '0;
            r_dv       <= 1'b0;
            r_se       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_flag <= 1'b0;
            r_pe       <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[0], RX_IN};
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_presc    <= w_presc_nxt;
            r_p_data   <= w_pdata_nxt;
            r_dv       <= w_dv_nxt;
            r_se       <= w_se_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_en   <= w_par_en_nxt;
            r_par_typ  <= w_par_typ_nxt;
            r_par_flag <= w_flag_nxt;
            r_pe       <= w_pe_nxt;
`endif
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_dv;
    assign stp_err    = r_se;

endmodule
`default_nettype wire
